// File: rtl/sar_search.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sar_search                                                   |
// | Description : Successive-approximation search controller. Drives a         |
// |               comparator's trial operand MSB-first and consumes its L/E/G  |
// |               flags to converge on the comparator's other operand.         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module sar_search #(
    parameter int WIDTH   = 4,
    parameter int CMP_LAT = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [WIDTH-1:0] trial,
    input  logic             E,
    input  logic             G,
    input  logic             L,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             found,
    output logic             err
);

    localparam int c_CNT_W = (CMP_LAT > 0) ? $clog2(CMP_LAT + 1) : 1;
    localparam int c_IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_PROBE  = 2'd1;
    localparam logic [1:0] c_ST_VERIFY = 2'd2;

    localparam logic [c_CNT_W-1:0] c_SAMPLE  = c_CNT_W'(CMP_LAT);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);
    localparam logic [c_IDX_W-1:0] c_IDX_TOP = c_IDX_W'(WIDTH - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_ONE = c_IDX_W'(1);
    localparam logic [WIDTH-1:0]   c_ONE     = WIDTH'(1);
    localparam logic [WIDTH-1:0]   c_MSB     = c_ONE << (WIDTH - 1);

    logic [1:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_IDX_W-1:0] r_idx;
    logic [WIDTH-1:0]   r_trial;
    logic [WIDTH-1:0]   r_result;
    logic               r_busy;
    logic               r_done;
    logic               r_found;
    logic               r_err;

    logic               w_sample;
    logic               w_onehot;
    logic [WIDTH-1:0]   w_cur_bit;
    logic [WIDTH-1:0]   w_next_bit;
    logic [WIDTH-1:0]   w_decided;

    assign w_sample   = (r_cnt == c_SAMPLE);
    assign w_onehot   = (E & ~G & ~L) | (~E & G & ~L) | (~E & ~G & L);
    assign w_cur_bit  = c_ONE << r_idx;
    assign w_next_bit = w_cur_bit >> 1;
    // Target below the trial means the bit under test overshoots and is dropped.
    assign w_decided  = L ? (r_trial & ~w_cur_bit) : r_trial;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= c_ST_IDLE;
            r_cnt    <= '0;
            r_idx    <= '0;
            r_trial  <= '0;
            r_result <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_found  <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (start) begin
                        r_trial  <= c_MSB;
                        r_idx    <= c_IDX_TOP;
                        r_cnt    <= '0;
                        r_busy   <= 1'b1;
                        r_result <= '0;
                        r_found  <= 1'b0;
                        r_err    <= 1'b0;
                        r_state  <= c_ST_PROBE;
                    end
                end
                c_ST_PROBE: begin
                    if (!w_sample) begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end else if (!w_onehot) begin
                        r_err    <= 1'b1;
                        r_found  <= 1'b0;
                        r_result <= r_trial;
                        r_done   <= 1'b1;
                        r_busy   <= 1'b0;
                        r_state  <= c_ST_IDLE;
                    end else if (E) begin
                        r_result <= r_trial;
                        r_found  <= 1'b1;
                        r_done   <= 1'b1;
                        r_busy   <= 1'b0;
                        r_state  <= c_ST_IDLE;
                    end else begin
                        r_cnt <= '0;
                        if (r_idx != '0) begin
                            r_trial <= w_decided | w_next_bit;
                            r_idx   <= r_idx - c_IDX_ONE;
                        end else begin
                            r_trial <= w_decided;
                            r_state <= c_ST_VERIFY;
                        end
                    end
                end
                c_ST_VERIFY: begin
                    if (!w_sample) begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end else begin
                        r_result <= r_trial;
                        r_found  <= w_onehot & E;
                        r_err    <= ~w_onehot;
                        r_done   <= 1'b1;
                        r_busy   <= 1'b0;
                        r_state  <= c_ST_IDLE;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign trial  = r_trial;
    assign busy   = r_busy;
    assign done   = r_done;
    assign result = r_result;
    assign found  = r_found;
    assign err    = r_err;

endmodule
`default_nettype wire
